alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts one instruction word, decodes it, reads the register file,

---
 rtl/alu_ctrl_pkg.sv | 68 ++++++
 rtl/alu_issue_ctrl_decode.sv | 74 +++++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: op classes, ALU opcode
// selects, FSM states and instruction field positions.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ALUR   = 4'd0,
    OP_ALUI   = 4'd1,
    OP_CMPR   = 4'd2,
    OP_CMPI   = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JAL    = 4'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [1:0] {
    BSRC_RS2,
    BSRC_SEXT,
    BSRC_ZEXT
  } bsrc_e;

  localparam logic [5:0] ALU_BF   = 6'h00;
  localparam logic [5:0] ALU_BEQ  = 6'h01;
  localparam logic [5:0] ALU_BNE  = 6'h02;
  localparam logic [5:0] ALU_BLT  = 6'h03;
  localparam logic [5:0] ALU_BGE  = 6'h05;
  localparam logic [5:0] ALU_BLTU = 6'h06;
  localparam logic [5:0] ALU_BGEU = 6'h07;
  localparam logic [5:0] ALU_BT   = 6'h0F;
  localparam logic [5:0] ALU_ADD  = 6'h10;
  localparam logic [5:0] ALU_SUB  = 6'h11;
  localparam logic [5:0] ALU_AND  = 6'h14;
  localparam logic [5:0] ALU_OR   = 6'h15;
  localparam logic [5:0] ALU_XOR  = 6'h16;
  localparam logic [5:0] ALU_MVHI = 6'h1B;
  localparam logic [5:0] ALU_SLL  = 6'h1C;
  localparam logic [5:0] ALU_SRL  = 6'h1D;
  localparam logic [5:0] ALU_SRA  = 6'h1E;
  localparam logic [5:0] ALU_JALR = 6'h20;

  localparam logic [3:0] FN_MVHI = 4'd11;

  localparam int OP_LSB     = 0;
  localparam int FN_LSB     = 4;
  localparam int IMM_LSB    = 8;
  localparam int RD_LSB     = 28;
  localparam int RS1_LSB    = 24;
  localparam int RS2_LSB    = 20;
  localparam int BR_RS1_LSB = 28;
  localparam int BR_RS2_LSB = 24;

  function automatic logic alu_fn_legal(input logic [3:0] fn);
    case (fn)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd11, 4'd12, 4'd13, 4'd14: alu_fn_legal = 1'b1;
      default:                                                 alu_fn_legal = 1'b0;
    endcase
  endfunction

  function automatic logic cmp_fn_legal(input logic [3:0] fn);
    cmp_fn_legal = (fn != 4'd4) && (fn != 4'd12);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational instruction decode: op/fn to ALU opsel, legality, register
// indices and operand-B source.
module alu_instr_decode
  import alu_ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int IMM_W  = 16
) (
  input  logic [31:0]       instr,
  output logic              legal,
  output logic [5:0]        opsel,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  output logic [REG_AW-1:0] rd,
  output bsrc_e             bsrc,
  output logic              is_branch,
  output logic              is_jal,
  output logic              is_mvhi,
  output logic [IMM_W-1:0]  imm
);

  logic [3:0] op;
  logic [3:0] fn;

  assign op  = instr[OP_LSB +: 4];
  assign fn  = instr[FN_LSB +: 4];
  assign imm = instr[IMM_LSB +: IMM_W];
  assign rd  = instr[RD_LSB +: REG_AW];

  // MVHI is an immediate-only operation, so it takes zext(imm) in both ALU forms.
  always_comb begin
    legal     = 1'b0;
    opsel     = ALU_BF;
    bsrc      = BSRC_RS2;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_mvhi   = 1'b0;
    raddr1    = instr[RS1_LSB +: REG_AW];
    raddr2    = instr[RS2_LSB +: REG_AW];
    case (op)
      OP_ALUR, OP_ALUI: begin
        legal   = alu_fn_legal(fn);
        opsel   = {2'b01, fn};
        is_mvhi = (fn == FN_MVHI);
        if (fn == FN_MVHI)    bsrc = BSRC_ZEXT;
        else if (op == OP_ALUI) bsrc = BSRC_SEXT;
      end
      OP_CMPR: begin
        legal = cmp_fn_legal(fn);
        opsel = {2'b00, fn};
      end
      OP_CMPI: begin
        legal = cmp_fn_legal(fn);
        opsel = {2'b00, fn};
        bsrc  = BSRC_SEXT;
      end
      OP_BRANCH: begin
        legal     = cmp_fn_legal(fn);
        opsel     = {2'b00, fn};
        is_branch = 1'b1;
        raddr1    = instr[BR_RS1_LSB +: REG_AW];
        raddr2    = instr[BR_RS2_LSB +: REG_AW];
      end
      OP_JAL: begin
        legal  = 1'b1;
        opsel  = ALU_JALR;
        bsrc   = BSRC_SEXT;
        is_jal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts one instruction, reads operands, drives
// the registered ALU and retires via writeback or branch redirect.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic [5:0]        alu_opsel,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_out,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_target,
  output logic              done,
  output logic              illegal_instr
);

  state_e            state;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;

  logic              dec_legal;
  logic [5:0]        dec_opsel;
  logic [REG_AW-1:0] dec_rd;
  bsrc_e             dec_bsrc;
  logic              dec_is_branch;
  logic              dec_is_jal;
  logic              dec_is_mvhi;
  logic [IMM_W-1:0]  dec_imm;

  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   imm_zext;
  logic [XLEN-1:0]   opnd_b;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   branch_tgt;

  alu_instr_decode #(
    .REG_AW (REG_AW),
    .IMM_W  (IMM_W)
  ) u_decode (
    .instr     (instr_q),
    .legal     (dec_legal),
    .opsel     (dec_opsel),
    .raddr1    (rf_raddr1),
    .raddr2    (rf_raddr2),
    .rd        (dec_rd),
    .bsrc      (dec_bsrc),
    .is_branch (dec_is_branch),
    .is_jal    (dec_is_jal),
    .is_mvhi   (dec_is_mvhi),
    .imm       (dec_imm)
  );

  assign imm_sext   = {{(XLEN-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
  assign imm_zext   = {{(XLEN-IMM_W){1'b0}}, dec_imm};
  assign pc_plus4   = pc_q + XLEN'(4);
  assign branch_tgt = pc_plus4 + (imm_sext << 2);

  // Ready is qualified by rst_n so it stays low for the whole reset window.
  assign instr_ready = rst_n && (state == S_IDLE);

  always_comb begin
    opnd_b = rf_rdata2;
    case (dec_bsrc)
      BSRC_SEXT: opnd_b = imm_sext;
      BSRC_ZEXT: opnd_b = imm_zext;
      default:   opnd_b = rf_rdata2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      alu_opsel     <= ALU_BF;
      alu_a         <= '0;
      alu_b         <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      br_taken      <= 1'b0;
      br_target     <= '0;
      done          <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      br_taken      <= 1'b0;
      br_target     <= '0;
      done          <= 1'b0;
      illegal_instr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            pc_q    <= pc;
            state   <= S_READ;
          end
        end
        S_READ: begin
          // Illegal instructions leave alu_* untouched so opsel stays a defined code.
          if (!dec_legal) begin
            illegal_instr <= 1'b1;
            state         <= S_IDLE;
          end else begin
            alu_opsel <= dec_opsel;
            alu_a     <= rf_rdata1;
            alu_b     <= opnd_b;
            state     <= S_EXEC;
          end
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (dec_is_branch) begin
            br_taken  <= alu_out[0];
            br_target <= branch_tgt;
          end else if (dec_is_jal) begin
            rf_we     <= 1'b1;
            rf_waddr  <= dec_rd;
            rf_wdata  <= pc_plus4;
            br_taken  <= 1'b1;
            br_target <= alu_out;
          end else begin
            rf_we    <= 1'b1;
            rf_waddr <= dec_rd;
            rf_wdata <= dec_is_mvhi ? {alu_out[XLEN-1:16], 16'h0000} : alu_out;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file, a
// registered ALU model and a scoreboard of expected retirements.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [5:0]  alu_opsel;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        done;
  logic        illegal_instr;

  logic [31:0] regs [16];

  typedef struct packed {
    logic        illegal;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        br;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  alu_issue_ctrl #(.XLEN(32), .REG_AW(4), .IMM_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .pc            (pc),
    .rf_raddr1     (rf_raddr1),
    .rf_raddr2     (rf_raddr2),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .alu_opsel     (alu_opsel),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .done          (done),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  // Stand-in for the external ALU: result registered one clock after operands.
  function automatic logic [31:0] aluModel(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h01:   aluModel = {31'b0, a == b};
      6'h02:   aluModel = {31'b0, a != b};
      6'h03:   aluModel = {31'b0, $signed(a) < $signed(b)};
      6'h05:   aluModel = {31'b0, $signed(a) >= $signed(b)};
      6'h06:   aluModel = {31'b0, a < b};
      6'h07:   aluModel = {31'b0, a >= b};
      6'h0F:   aluModel = 32'd1;
      6'h10:   aluModel = a + b;
      6'h11:   aluModel = a - b;
      6'h14:   aluModel = a & b;
      6'h15:   aluModel = a | b;
      6'h16:   aluModel = a ^ b;
      6'h1B:   aluModel = b << 16;
      6'h1C:   aluModel = a << b[4:0];
      6'h1D:   aluModel = a >> b[4:0];
      6'h1E:   aluModel = $signed(a) >>> b[4:0];
      6'h20:   aluModel = a + (b << 2);
      default: aluModel = 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_out <= aluModel(alu_opsel, alu_a, alu_b);

  function automatic logic [31:0] rtype(input logic [3:0] op, input logic [3:0] fn,
                                        input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    rtype = {rd, rs1, rs2, 12'h000, fn, op};
  endfunction

  function automatic logic [31:0] itype(input logic [3:0] op, input logic [3:0] fn,
                                        input logic [3:0] rd, input logic [3:0] rs1, input logic [15:0] imm);
    itype = {rd, rs1, imm, fn, op};
  endfunction

  function automatic logic [31:0] btype(input logic [3:0] fn, input logic [3:0] rs1,
                                        input logic [3:0] rs2, input logic [15:0] imm);
    btype = {rs1, rs2, imm, fn, 4'd4};
  endfunction

  function automatic exp_t mk(input logic ill, input logic we, input logic [3:0] waddr,
                              input logic [31:0] wdata, input logic br, input logic [31:0] target);
    mk = '{illegal: ill, we: we, waddr: waddr, wdata: wdata, br: br, target: target};
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input exp_t e);
    int w;
    w = 0;
    sb.push_back(e);
    @(negedge clk);
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    expectEq("ready_wait", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = i;
    pc          = p;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || illegal_instr) && n < 10);
    expectEq({tag, "_seen"}, 32'(done || illegal_instr), 32'd1);
    if (exp_lat >= 0) expectEq({tag, "_latency"}, 32'(n - 1), 32'(exp_lat));
    expectEq({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      expectEq({tag, "_illegal"}, 32'(illegal_instr), 32'(e.illegal));
      expectEq({tag, "_done"}, 32'(done), 32'(!e.illegal));
      expectEq({tag, "_rf_we"}, 32'(rf_we), 32'(e.we));
      if (e.we) begin
        expectEq({tag, "_waddr"}, 32'(rf_waddr), 32'(e.waddr));
        expectEq({tag, "_wdata"}, rf_wdata, e.wdata);
      end
      expectEq({tag, "_br_taken"}, 32'(br_taken), 32'(e.br));
      if (e.br) expectEq({tag, "_br_target"}, br_target, e.target);
      expectEq({tag, "_ready"}, 32'(instr_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_wb;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1]  = 32'd10;
    regs[5]  = 32'd5;
    regs[7]  = 32'd7;
    regs[8]  = 32'd3;
    regs[9]  = 32'd3;
    regs[10] = 32'h200;
    regs[11] = 32'd1;
    regs[12] = 32'hFFFF_FFFF;

    #12;
    expectEq("rst_ready", 32'(instr_ready), 32'd0);
    expectEq("rst_done", 32'(done), 32'd0);
    expectEq("rst_opsel", 32'(alu_opsel), 32'd0);
    expectEq("rst_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expectEq("post_rst_ready", 32'(instr_ready), 32'd1);

    applyStimulus(rtype(4'd0, 4'd0, 4'd3, 4'd5, 4'd7), 32'h0, mk(0, 1, 4'd3, 32'd12, 0, 32'h0));
    checkOutput("alur_add", 3);
    applyStimulus(itype(4'd1, 4'd1, 4'd2, 4'd1, 16'hFFFF), 32'h0, mk(0, 1, 4'd2, 32'd11, 0, 32'h0));
    checkOutput("alui_sub", 3);
    applyStimulus(itype(4'd1, 4'd11, 4'd4, 4'd1, 16'hABCD), 32'h0, mk(0, 1, 4'd4, 32'hABCD_0000, 0, 32'h0));
    checkOutput("mvhi", 3);
    applyStimulus(btype(4'd1, 4'd8, 4'd9, 16'd2), 32'h100, mk(0, 0, 4'd0, 32'h0, 1, 32'h10C));
    checkOutput("beq_taken", 3);
    applyStimulus(btype(4'd2, 4'd8, 4'd9, 16'd2), 32'h100, mk(0, 0, 4'd0, 32'h0, 0, 32'h0));
    checkOutput("bne_not_taken", 3);
    applyStimulus(btype(4'd1, 4'd8, 4'd9, 16'hFFFF), 32'h100, mk(0, 0, 4'd0, 32'h0, 1, 32'h100));
    checkOutput("beq_back", 3);
    applyStimulus(itype(4'd5, 4'd0, 4'd6, 4'd10, 16'd3), 32'h40, mk(0, 1, 4'd6, 32'h44, 1, 32'h20C));
    checkOutput("jal", 3);
    applyStimulus(itype(4'd5, 4'd0, 4'd6, 4'd10, 16'hFFFF), 32'hFFFF_FFFC, mk(0, 1, 4'd6, 32'h0, 1, 32'h1FC));
    checkOutput("jal_wrap", 3);
    applyStimulus(rtype(4'd2, 4'd6, 4'd14, 4'd11, 4'd12), 32'h0, mk(0, 1, 4'd14, 32'd1, 0, 32'h0));
    checkOutput("cmpr_bltu", 3);
    applyStimulus(itype(4'd3, 4'd3, 4'd15, 4'd12, 16'h0000), 32'h0, mk(0, 1, 4'd15, 32'd1, 0, 32'h0));
    checkOutput("cmpi_blt", 3);

    applyStimulus(32'h0000_000F, 32'h0, mk(1, 0, 4'd0, 32'h0, 0, 32'h0));
    checkOutput("illegal_op", 1);
    applyStimulus(rtype(4'd0, 4'd2, 4'd3, 4'd5, 4'd7), 32'h0, mk(1, 0, 4'd0, 32'h0, 0, 32'h0));
    checkOutput("illegal_alu_fn", 1);
    applyStimulus(rtype(4'd2, 4'd4, 4'd3, 4'd5, 4'd7), 32'h0, mk(1, 0, 4'd0, 32'h0, 0, 32'h0));
    checkOutput("illegal_cmp_fn", 1);

    // Valid held through a busy window: the second word must wait for IDLE.
    sb.push_back(mk(0, 1, 4'd3, 32'd12, 0, 32'h0));
    sb.push_back(mk(0, 1, 4'd2, 32'hFFFF_FFFE, 0, 32'h0));
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = rtype(4'd0, 4'd0, 4'd3, 4'd5, 4'd7);
    @(posedge clk);
    #1;
    instr = rtype(4'd0, 4'd6, 4'd2, 4'd11, 4'd12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expectEq("busy_ready", 32'(instr_ready), 32'd0);
    end
    checkOutput("hold_first", -1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    checkOutput("hold_second", 3);

    // Reset during EXEC drops the instruction.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = rtype(4'd0, 4'd0, 4'd13, 4'd5, 4'd7);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expectEq("midrst_opsel", 32'(alu_opsel), 32'd0);
    expectEq("midrst_alu_a", alu_a, 32'd0);
    expectEq("midrst_alu_b", alu_b, 32'd0);
    expectEq("midrst_ready", 32'(instr_ready), 32'd0);
    expectEq("midrst_raddr1", 32'(rf_raddr1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expectEq("midrst_ready_after", 32'(instr_ready), 32'd1);
    saw_wb = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || rf_we || br_taken) saw_wb = 1'b1;
    end
    expectEq("midrst_no_wb", 32'(saw_wb), 32'd0);

    applyStimulus(rtype(4'd0, 4'd0, 4'd3, 4'd5, 4'd7), 32'h0, mk(0, 1, 4'd3, 32'd12, 0, 32'h0));
    checkOutput("after_rst_add", 3);

    expectEq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
